// File: rtl/led_pattern_ctrl_if.sv
// Runtime configuration port of led_pattern_ctrl.
// One accepted valid/ready beat rewrites one channel's mode, timing and brightness.
interface led_pattern_ctrl_if #(
    parameter int CHAN_W   = 2,
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8,
    parameter int BURST_W  = 4
);
    logic                valid;
    logic                ready;
    logic [CHAN_W-1:0]   chan;
    logic [1:0]          mode;
    logic [PERIOD_W-1:0] half_period;
    logic [PWM_W-1:0]    duty;
    logic [BURST_W-1:0]  burst;

    modport master (output valid, chan, mode, half_period, duty, burst, input ready);
    modport slave  (input valid, chan, mode, half_period, duty, burst, output ready);
endinterface

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: shared tick prescaler, per-channel
// OFF/ON/BLINK/BURST sequencing, PWM brightness and a registered LED drive.
module led_pattern_ctrl #(
    parameter int CHANNELS = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1_000,
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8,
    parameter int BURST_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    led_pattern_ctrl_if.slave   cfg,
    output logic                tick,
    output logic [CHANNELS-1:0] led
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = $clog2(DIV);
    localparam int CNT_W = PERIOD_W + 2;

    typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST} mode_t;
    typedef enum logic [1:0] {FLASH_ON, FLASH_OFF, GAP} burst_state_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_W-1:0]    pwm_cnt;
    mode_t               mode        [CHANNELS];
    logic [PERIOD_W-1:0] half_period [CHANNELS];
    logic [PWM_W-1:0]    duty        [CHANNELS];
    logic [BURST_W-1:0]  burst       [CHANNELS];
    logic [CNT_W-1:0]    tick_cnt    [CHANNELS];
    logic [CNT_W-1:0]    limit       [CHANNELS];
    logic [BURST_W-1:0]  flashes     [CHANNELS];
    burst_state_t        state       [CHANNELS];
    logic [CHANNELS-1:0] phase;
    logic [CHANNELS-1:0] lit;
    logic [CHANNELS-1:0] bright;
    logic                write_ok;
    logic [PERIOD_W-1:0] cfg_hp;
    logic [BURST_W-1:0]  cfg_burst;

    assign tick      = (pre_cnt == PRE_W'(DIV - 1));
    assign write_ok  = cfg.valid && cfg.ready && (32'(cfg.chan) < CHANNELS);
    assign cfg_hp    = (cfg.half_period == '0) ? PERIOD_W'(1) : cfg.half_period;
    assign cfg_burst = (cfg.burst == '0) ? BURST_W'(1) : cfg.burst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            cfg.ready <= 1'b0;
        end else begin
            pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            cfg.ready <= 1'b1;
        end
    end

    // One shared tick counter per channel; the gap simply uses a 4x longer terminal count.
    always_comb begin
        for (int n = 0; n < CHANNELS; n++) begin
            limit[n] = (mode[n] == MODE_BURST && state[n] == GAP)
                     ? {half_period[n], 2'b00} : {2'b00, half_period[n]};
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < CHANNELS; n++) begin
            if (rst) begin
                mode[n]        <= MODE_OFF;
                half_period[n] <= PERIOD_W'(1);
                duty[n]        <= '1;
                burst[n]       <= BURST_W'(1);
                tick_cnt[n]    <= '0;
                flashes[n]     <= BURST_W'(1);
                phase[n]       <= 1'b1;
                state[n]       <= FLASH_ON;
            end else if (write_ok && 32'(cfg.chan) == n) begin
                mode[n]        <= mode_t'(cfg.mode);
                half_period[n] <= cfg_hp;
                duty[n]        <= cfg.duty;
                burst[n]       <= cfg_burst;
                tick_cnt[n]    <= '0;
                flashes[n]     <= BURST_W'(1);
                phase[n]       <= 1'b1;
                state[n]       <= FLASH_ON;
            end else if (tick) begin
                if (tick_cnt[n] == limit[n] - 1'b1) begin
                    tick_cnt[n] <= '0;
                    if (mode[n] == MODE_BLINK) begin
                        phase[n] <= ~phase[n];
                    end
                    if (mode[n] == MODE_BURST) begin
                        case (state[n])
                            FLASH_ON:  state[n] <= FLASH_OFF;
                            FLASH_OFF: begin
                                if (flashes[n] == burst[n]) begin
                                    state[n] <= GAP;
                                end else begin
                                    state[n]   <= FLASH_ON;
                                    flashes[n] <= flashes[n] + 1'b1;
                                end
                            end
                            GAP: begin
                                state[n]   <= FLASH_ON;
                                flashes[n] <= BURST_W'(1);
                            end
                            default: state[n] <= FLASH_ON;
                        endcase
                    end
                end else begin
                    tick_cnt[n] <= tick_cnt[n] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lit    = '0;
        bright = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            case (mode[n])
                MODE_ON:    lit[n] = 1'b1;
                MODE_BLINK: lit[n] = phase[n];
                MODE_BURST: lit[n] = (state[n] == FLASH_ON);
                default:    lit[n] = 1'b0;
            endcase
            bright[n] = (pwm_cnt < duty[n]) || (duty[n] == '1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else begin
            led <= lit & bright & {CHANNELS{enable}};
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed self-checking bench for led_pattern_ctrl with a 10-clock tick
// (CLK_HZ=100, TICK_HZ=10) and three channels so channel 3 is out of range.
module tb_led_pattern_ctrl;
    localparam int CHANNELS = 3;
    localparam int PERIOD_W = 16;
    localparam int PWM_W    = 8;
    localparam int BURST_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                tick;
    logic [CHANNELS-1:0] led;
    int                  vectors     = 0;
    int                  miscompares = 0;

    led_pattern_ctrl_if #(.CHAN_W(2), .PERIOD_W(PERIOD_W), .PWM_W(PWM_W), .BURST_W(BURST_W)) cfg_bus ();

    led_pattern_ctrl #(
        .CHANNELS(CHANNELS), .CLK_HZ(100), .TICK_HZ(10),
        .PERIOD_W(PERIOD_W), .PWM_W(PWM_W), .BURST_W(BURST_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg(cfg_bus), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Holds valid for exactly one edge; the write is accepted on that edge.
    task automatic applyStimulus(input logic [1:0] chan, input logic [1:0] mode, input logic [15:0] hp,
                                 input logic [7:0] duty, input logic [3:0] burst);
        cfg_bus.valid       = 1'b1;
        cfg_bus.chan        = chan;
        cfg_bus.mode        = mode;
        cfg_bus.half_period = hp;
        cfg_bus.duty        = duty;
        cfg_bus.burst       = burst;
        step(1);
        cfg_bus.valid = 1'b0;
    endtask

    task automatic waitTick();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!tick && n < 20);
        checkOutput("tick_seen", 32'(tick), 32'd1);
    endtask

    task automatic countHigh(input int bit_idx, input int cycles, output int highs);
        highs = 0;
        repeat (cycles) begin
            step(1);
            if (bit_idx < 0) highs += (led != '0) ? 1 : 0;
            else             highs += int'(led[bit_idx]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        int          highs;
        logic        prev;
        bit          found;
        logic [8:0]  burst_exp;
        logic [6:0]  hp0_exp;

        burst_exp = 9'b100000101;
        hp0_exp   = 7'b1000001;
        rst = 1'b1;
        enable = 1'b1;
        cfg_bus.valid = 1'b0;
        cfg_bus.chan = '0;
        cfg_bus.mode = '0;
        cfg_bus.half_period = '0;
        cfg_bus.duty = '0;
        cfg_bus.burst = '0;

        // Reset and timebase
        step(3);
        checkOutput("reset_led", 32'(led), 32'd0);
        checkOutput("reset_ready", 32'(cfg_bus.ready), 32'd0);
        checkOutput("reset_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        step(1);
        checkOutput("ready_after_reset", 32'(cfg_bus.ready), 32'd1);
        checkOutput("no_tick_first", 32'(tick), 32'd0);
        n = 0;
        do begin step(1); n++; end while (!tick && n < 30);
        checkOutput("first_tick_delay", 32'(n), 32'd8);
        n = 0;
        do begin step(1); n++; end while (!tick && n < 30);
        checkOutput("tick_interval", 32'(n), 32'd10);
        checkOutput("led_idle", 32'(led), 32'd0);

        // BLINK ch0 hp=3, written on a tick edge
        waitTick();
        applyStimulus(2'd0, 2'b10, 16'd3, 8'hFF, 4'd1);
        checkOutput("blink_w0", 32'(led[0]), 32'd0);
        step(1);
        checkOutput("blink_w1", 32'(led[0]), 32'd1);
        checkOutput("blink_others", 32'(led[2:1]), 32'd0);
        step(29);
        checkOutput("blink_w30", 32'(led[0]), 32'd1);
        step(1);
        checkOutput("blink_w31", 32'(led[0]), 32'd0);
        step(29);
        checkOutput("blink_w60", 32'(led[0]), 32'd0);
        step(1);
        checkOutput("blink_w61", 32'(led[0]), 32'd1);

        // BURST ch1 hp=1 burst=2, sampled mid-way through each tick interval
        waitTick();
        applyStimulus(2'd1, 2'b11, 16'd1, 8'hFF, 4'd2);
        step(5);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) step(10);
            checkOutput($sformatf("burst_k%0d", k), 32'(led[1]), 32'(burst_exp[k]));
        end

        // PWM ch2 duty=0x40 and enable gating
        applyStimulus(2'd2, 2'b01, 16'd1, 8'h40, 4'd1);
        step(2);
        countHigh(2, 256, highs);
        checkOutput("pwm_duty40", 32'(highs), 32'd64);
        prev = led[2];
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            step(1); n++;
            if (!prev && led[2]) found = 1'b1;
            prev = led[2];
        end
        checkOutput("pwm_rise_found", 32'(found), 32'd1);
        enable = 1'b0;
        step(1);
        checkOutput("disable_led", 32'(led), 32'd0);
        step(99);
        checkOutput("disable_hold", 32'(led), 32'd0);
        enable = 1'b1;
        prev = led[2];
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            step(1); n++;
            if (!prev && led[2]) found = 1'b1;
            prev = led[2];
        end
        checkOutput("pwm_phase_kept", 32'(n), 32'd156);
        applyStimulus(2'd2, 2'b01, 16'd1, 8'h00, 4'd1);
        step(1);
        countHigh(2, 256, highs);
        checkOutput("pwm_duty0", 32'(highs), 32'd0);

        // Out-of-range channel write must not light anything
        applyStimulus(2'd0, 2'b00, 16'd1, 8'hFF, 4'd1);
        applyStimulus(2'd1, 2'b00, 16'd1, 8'hFF, 4'd1);
        step(2);
        applyStimulus(2'd3, 2'b01, 16'd1, 8'hFF, 4'd1);
        countHigh(-1, 40, highs);
        checkOutput("oob_write", 32'(highs), 32'd0);

        // hp=0 and burst=0 behave as 1
        waitTick();
        applyStimulus(2'd0, 2'b11, 16'd0, 8'hFF, 4'd0);
        step(5);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step(10);
            checkOutput($sformatf("hp0_k%0d", k), 32'(led[0]), 32'(hp0_exp[k]));
        end

        // Reset while ch1 sits in its gap
        waitTick();
        applyStimulus(2'd1, 2'b11, 16'd1, 8'hFF, 4'd2);
        step(25);
        checkOutput("rb_flash2", 32'(led[1]), 32'd1);
        step(20);
        checkOutput("rb_gap", 32'(led[1]), 32'd0);
        rst = 1'b1;
        step(1);
        checkOutput("rb_led", 32'(led), 32'd0);
        checkOutput("rb_ready", 32'(cfg_bus.ready), 32'd0);
        checkOutput("rb_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        step(1);
        checkOutput("rb_ready_back", 32'(cfg_bus.ready), 32'd1);
        countHigh(-1, 100, highs);
        checkOutput("rb_stays_off", 32'(highs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Multi-channel LED pattern generator; next generation of the single-LED blinker. A shared prescaler produces a timebase tick. Each channel runs one of four modes: OFF, ON, BLINK or BURST, with a per-channel half-period and PWM brightness. Channels are configured at runtime via a valid/ready write port. Sits between board-level control logic and the LED pins.

Parameters:
CHANNELS, 4, number of LED channels (1..16)
CLK_HZ, 50_000_000, i_clk frequency in Hz
TICK_HZ, 1_000, timebase tick rate in Hz; prescaler divide = CLK_HZ/TICK_HZ (integer, >=2)
PERIOD_W, 16, width of half-period field, in ticks
PWM_W, 8, brightness PWM resolution in bits
BURST_W, 4, width of burst-count field

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_enable  in  1  global output enable; 0 forces o_led to 0 while timers keep running
i_cfg_valid  in  1  config write request
i_cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
i_cfg_mode  in  2  00 OFF, 01 ON, 10 BLINK, 11 BURST
i_cfg_half_period  in  PERIOD_W  half-period in ticks; 0 treated as 1
i_cfg_duty  in  PWM_W  brightness; 0 = dark, all-ones = full on
i_cfg_burst  in  BURST_W  flashes per burst; 0 treated as 1
o_cfg_ready  out  1  write accepted when valid & ready
o_tick  out  1  one-cycle timebase pulse
o_led  out  CHANNELS  registered LED drive

Behaviour:
- Reset (i_rst=1 at a clock edge): all channels set to OFF, half_period=1, duty=all-ones, burst=1. Clears all counters and the prescaler. o_led=0, o_tick=0, o_cfg_ready=0. o_cfg_ready goes to 1 on the first cycle after i_rst deasserts.
- Reset mid-pattern aborts all channels immediately. Config is not retained.
- Prescaler: counts 0..DIV-1 (DIV = CLK_HZ/TICK_HZ). o_tick=1 for the single cycle in which the count equals DIV-1, then the count wraps to 0.
- Config: accepted on any edge with i_cfg_valid & o_cfg_ready. No backpressure after reset, so o_cfg_ready stays 1.
  - i_cfg_chan >= CHANNELS: write dropped, no state change.
  - On acceptance, the channel latches mode/half_period/duty/burst, clears its tick counter, sets its state to FLASH_ON and loads its flash counter.
  - A write on the same edge as a tick takes priority; that tick is not counted for that channel.
- Per-channel lit state L:
  - OFF: L=0.
  - ON: L=1.
  - BLINK: phase starts on. On each tick, if tick_cnt == hp-1, toggle phase and clear tick_cnt; otherwise increment tick_cnt. L=phase.
  - BURST: FSM with states FLASH_ON, FLASH_OFF, GAP. L=1 only in FLASH_ON. Counting is in ticks.
    - FLASH_ON lasts hp ticks, then goes to FLASH_OFF.
    - FLASH_OFF lasts hp ticks. Then, if flashes_done == burst, go to GAP; otherwise go to FLASH_ON and increment flashes_done.
    - GAP lasts 4*hp ticks (counter width PERIOD_W+2), then goes to FLASH_ON with flashes_done=1.
- PWM: a free-running PWM_W counter increments every clock and wraps. Bright = (pwm_cnt < duty) | (duty == all-ones).
- Output: o_led[n] <= L[n] & bright & i_enable. This register adds one cycle of latency from internal state and from i_enable.
- Mode change mid-pattern restarts the pattern from FLASH_ON / phase-on. No glitch beyond that one-cycle latency.
- All counter arithmetic is unsigned and saturation-free. Compares use the latched, zero-corrected values.

Test Plan:
- Reset and tick (CLK_HZ=100, TICK_HZ=10): assert i_rst for 3 cycles then release -> o_led=0; o_cfg_ready=1 from the first post-reset cycle; o_tick pulses every 10 clocks.
- BLINK: write ch0 mode=10, hp=3, duty=FF -> o_led[0] is high for 3 ticks (30 clocks), low for 3 ticks, repeating. Other channels stay 0.
- BURST: write ch1 mode=11, hp=1, burst=2 -> sequence per tick on,off,on,off,off,off,off,off (the last four are the 4-tick gap), then repeats.
- PWM and enable: ch2 mode=01, duty=0x40 -> o_led[2] high for 64 of every 256 clocks. Drop i_enable -> o_led=0 one cycle later, and the pattern keeps its phase on re-enable. duty=0 -> never high.
- Edge writes: write to chan=CHANNELS (out of range) -> no change on any channel. A write coincident with o_tick restarts the channel with tick_cnt=0. hp=0 behaves as hp=1, and burst=0 as burst=1.
- Reset mid-burst: assert i_rst while ch1 is in GAP -> o_led=0 on the next cycle; after release ch1 stays OFF until rewritten.
